// File: rtl/intr_ctrl_pkg.sv
// Shared definitions for the interrupt controller.
//   N_IRQ     : number of request lines (8, matches the control-unit buses)
//   irq_vec_t : one bit per request line, also used for one-hot line codes
//   INTR_NONE : the "no line" one-hot code
package intr_pkg;

    localparam int N_IRQ = 8;

    typedef logic [N_IRQ-1:0] irq_vec_t;

    localparam irq_vec_t INTR_NONE = 8'h00;

endpackage

// File: rtl/intr_ctrl_if.sv
// Signal bundle between the interrupt controller and the control unit.
//   irq           : raw request lines, bit 0 highest priority
//   s_intr        : call/return strobe from the control unit
//   s_call_intr   : one-hot line being accepted
//   s_return_intr : one-hot line being retired (JRINTR)
//   min_bit_s     : one-hot highest-priority pending request, or 0
//   min_bit_a     : one-hot highest-priority in-service line, or 0
//   lost          : sticky per-line "request edge dropped" flags
// Modports: master = control unit / request source, slave = intr_ctrl.
interface intr_ctrl_if;
    import intr_pkg::*;

    irq_vec_t irq;
    logic     s_intr;
    irq_vec_t s_call_intr;
    irq_vec_t s_return_intr;
    irq_vec_t min_bit_s;
    irq_vec_t min_bit_a;
    irq_vec_t lost;

    modport master (
        output irq, s_intr, s_call_intr, s_return_intr,
        input  min_bit_s, min_bit_a, lost
    );

    modport slave (
        input  irq, s_intr, s_call_intr, s_return_intr,
        output min_bit_s, min_bit_a, lost
    );

endinterface

// File: rtl/intr_ctrl_prio_onehot.sv
// Lowest-set-bit isolator: onehot = vec & (~vec + 1).
//   vec    : input bit vector
//   onehot : only the lowest-index set bit of vec, or 0 when vec is 0
module prio_onehot
    import intr_pkg::*;
(
    input  irq_vec_t vec,
    output irq_vec_t onehot
);

    assign onehot = vec & (~vec + irq_vec_t'(1));

endmodule

// File: rtl/intr_ctrl.sv
// Edge-triggered, priority-ordered interrupt controller with nesting.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-low reset
//   bus   : intr_ctrl_if.slave (irq, s_intr, s_call_intr, s_return_intr in;
//           min_bit_s, min_bit_a, lost out)
// Build option: define INTR_SYNC_EN to pass irq through a 2-flop
// synchronizer (adds 2 clocks of request latency).
module intr_ctrl
    import intr_pkg::*;
#(
    parameter int N_IRQ = 8
) (
    input  logic        clk,
    input  logic        reset,
    intr_ctrl_if.slave  bus
);

    logic [N_IRQ-1:0] pend;
    logic [N_IRQ-1:0] insrv;
    logic [N_IRQ-1:0] lost_q;
    logic [N_IRQ-1:0] irq_q;
    logic [N_IRQ-1:0] irq_s;

    logic [N_IRQ-1:0] edge_det;
    logic [N_IRQ-1:0] call_eff;
    logic [N_IRQ-1:0] ret_eff;
    logic [N_IRQ-1:0] pend_n;
    logic [N_IRQ-1:0] insrv_n;
    logic [N_IRQ-1:0] lost_n;

`ifdef INTR_SYNC_EN
    logic [N_IRQ-1:0] sync1;
    logic [N_IRQ-1:0] sync2;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= bus.irq;
            sync2 <= sync1;
        end
    end

    assign irq_s = sync2;
`else
    assign irq_s = bus.irq;
`endif

    always_comb begin
        edge_det = irq_s & ~irq_q;
        call_eff = bus.s_intr ? bus.s_call_intr   : INTR_NONE;
        ret_eff  = bus.s_intr ? bus.s_return_intr : INTR_NONE;

        // A new edge wins over acceptance so a request arriving while the
        // line is being accepted is kept pending.
        pend_n   = (pend & ~call_eff) | edge_det;

        // Return clears first, then call sets.
        insrv_n  = (insrv & ~ret_eff) | call_eff;

        lost_n   = lost_q | (edge_det & pend & ~call_eff);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pend   <= '0;
            insrv  <= '0;
            lost_q <= '0;
            // irq_q keeps following irq_s during reset so a line held high
            // through reset release is not seen as a fresh edge; with irq_s
            // low in reset (or synchronizer flops cleared) this is 0.
            irq_q  <= irq_s;
        end else begin
            pend   <= pend_n;
            insrv  <= insrv_n;
            lost_q <= lost_n;
            irq_q  <= irq_s;
        end
    end

    prio_onehot u_prio_pend (
        .vec    (pend),
        .onehot (bus.min_bit_s)
    );

    prio_onehot u_prio_insrv (
        .vec    (insrv),
        .onehot (bus.min_bit_a)
    );

    assign bus.lost = lost_q;

endmodule

// File: tb/tb_intr_ctrl.sv
module tb_intr_ctrl;

    typedef struct {
        logic [7:0] irq;
        logic       s_intr;
        logic [7:0] call;
        logic [7:0] ret;
        logic [7:0] exp_s;
        logic [7:0] exp_a;
        logic [7:0] exp_lost;
    } vec_t;

    typedef struct {
        string      name;
        logic [7:0] exp_s;
        logic [7:0] exp_a;
        logic [7:0] exp_lost;
    } exp_t;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_bad;
    exp_t sb[$];
    vec_t tbl[22];

    intr_ctrl_if bus ();

    intr_ctrl #(.N_IRQ(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check_front();
        exp_t e;
        if (sb.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL scoreboard: got empty queue, required an expectation");
            return;
        end
        e = sb.pop_front();
        n_vec++;
        if (bus.min_bit_s !== e.exp_s || bus.min_bit_a !== e.exp_a || bus.lost !== e.exp_lost) begin
            n_bad++;
            $display("FAIL %s: got s=%h a=%h lost=%h, required s=%h a=%h lost=%h",
                     e.name, bus.min_bit_s, bus.min_bit_a, bus.lost,
                     e.exp_s, e.exp_a, e.exp_lost);
        end
    endtask

    task automatic drive(input logic [7:0] irq, input logic s_intr,
                         input logic [7:0] call, input logic [7:0] ret,
                         input string name, input logic [7:0] es,
                         input logic [7:0] ea, input logic [7:0] el);
        exp_t e;
        @(negedge clk);
        bus.irq           = irq;
        bus.s_intr        = s_intr;
        bus.s_call_intr   = call;
        bus.s_return_intr = ret;
        e.name = name; e.exp_s = es; e.exp_a = ea; e.exp_lost = el;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_front();
    endtask

    // Hold reset for two edges with irq at the given level, check cleared
    // outputs, then release.
    task automatic do_reset(input logic [7:0] irq, input string name);
        @(negedge clk);
        reset = 1'b0;
        drive(irq, 1'b0, 8'h00, 8'h00, name, 8'h00, 8'h00, 8'h00);
        drive(irq, 1'b0, 8'h00, 8'h00, name, 8'h00, 8'h00, 8'h00);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        reset = 1'b0;
        bus.irq = 8'h00;
        bus.s_intr = 1'b0;
        bus.s_call_intr = 8'h00;
        bus.s_return_intr = 8'h00;

        //            irq    s  call   ret    exp_s  exp_a  lost
        tbl[0]  = '{8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}; // idle
        tbl[1]  = '{8'h10, 0, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00}; // edge line 4
        tbl[2]  = '{8'h00, 0, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00}; // pending held
        tbl[3]  = '{8'h04, 0, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00}; // pend=14
        tbl[4]  = '{8'h00, 1, 8'h04, 8'h00, 8'h10, 8'h04, 8'h00}; // call 04
        tbl[5]  = '{8'h00, 1, 8'h00, 8'h04, 8'h10, 8'h00, 8'h00}; // return 04
        tbl[6]  = '{8'h00, 1, 8'h10, 8'h00, 8'h00, 8'h10, 8'h00}; // call 10
        tbl[7]  = '{8'h01, 0, 8'h00, 8'h00, 8'h01, 8'h10, 8'h00}; // edge line 0
        tbl[8]  = '{8'h00, 1, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00}; // nest call 01
        tbl[9]  = '{8'h00, 1, 8'h00, 8'h01, 8'h00, 8'h10, 8'h00}; // return 01
        tbl[10] = '{8'h00, 0, 8'hFF, 8'hFF, 8'h00, 8'h10, 8'h00}; // strobe low
        tbl[11] = '{8'h00, 1, 8'h20, 8'h10, 8'h00, 8'h20, 8'h00}; // call+ret
        tbl[12] = '{8'h00, 1, 8'h20, 8'h20, 8'h00, 8'h20, 8'h00}; // same bit
        tbl[13] = '{8'h00, 1, 8'h00, 8'h02, 8'h00, 8'h20, 8'h00}; // ret not insrv
        tbl[14] = '{8'h08, 0, 8'h00, 8'h00, 8'h08, 8'h20, 8'h00}; // edge line 3
        tbl[15] = '{8'h00, 0, 8'h00, 8'h00, 8'h08, 8'h20, 8'h00};
        tbl[16] = '{8'h08, 0, 8'h00, 8'h00, 8'h08, 8'h20, 8'h08}; // lost[3]
        tbl[17] = '{8'h00, 0, 8'h00, 8'h00, 8'h08, 8'h20, 8'h08};
        tbl[18] = '{8'h04, 1, 8'h04, 8'h00, 8'h04, 8'h04, 8'h08}; // edge+call
        tbl[19] = '{8'h00, 0, 8'h00, 8'h00, 8'h04, 8'h04, 8'h08};
        tbl[20] = '{8'h04, 1, 8'h04, 8'h00, 8'h04, 8'h04, 8'h08}; // edge+call, pend set
        tbl[21] = '{8'h00, 1, 8'h0C, 8'hFF, 8'h00, 8'h04, 8'h08}; // ret all, call 0C

        do_reset(8'h00, "reset_state");

        for (int i = 0; i < 22; i++) begin
            drive(tbl[i].irq, tbl[i].s_intr, tbl[i].call, tbl[i].ret,
                  $sformatf("tbl%0d", i), tbl[i].exp_s, tbl[i].exp_a, tbl[i].exp_lost);
        end

        // lost is sticky only until reset
        do_reset(8'h00, "reset_clears_lost");
        drive(8'h00, 1'b0, 8'h00, 8'h00, "post_reset_idle", 8'h00, 8'h00, 8'h00);

        // irq held high through reset release must not raise a request
        do_reset(8'hFF, "reset_irq_high");
        for (int i = 0; i < 4; i++) begin
            drive(8'hFF, 1'b0, 8'h00, 8'h00, $sformatf("held_high%0d", i),
                  8'h00, 8'h00, 8'h00);
        end
        // a real edge after that still registers with 1-clock latency
        drive(8'hFE, 1'b0, 8'h00, 8'h00, "drop_line0", 8'h00, 8'h00, 8'h00);
        drive(8'hFF, 1'b0, 8'h00, 8'h00, "reedge_line0", 8'h01, 8'h00, 8'h00);

        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d leftover, required 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
